video_timing_gen: RTL
=====================

# video_timing_gen

Source end of the video bus: generates the horizontal/vertical counters, sync and blanking flags for 800x600@60 Hz (40 MHz pixel clock) and packs them, together with pixel clock and RGB, onto the shared video bus. Sits at the head of the video pipeline. Drawing stages consume the bus downstream, and the sync/blank output stage at the tail drives the connector.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch
- H_SYNC, 128, hsync pulse width
- H_BP, 88, horizontal back porch (H_TOTAL = 1056)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch
- V_SYNC, 4, vsync pulse width
- V_BP, 23, vertical back porch (V_TOTAL = 628)

Ports:
- pclk  in  1  pixel clock, 40 MHz; single clock domain
- rst  in  1  synchronous, active-high reset
- video_bus_out  out  `BUS_WIDTH+1  packed video bus; field positions from video_bus.h
- frame_start  out  1  one-cycle pulse, coincident with the bus beat hcount=0, vcount=0

## Operation
- Bus fields:
  - BUS_HCOUNT and BUS_VCOUNT: 11 bits each.
  - BUS_HSYNC, BUS_VSYNC, BUS_HBLNK, BUS_VBLNK: 1 bit each.
  - BUS_RGB: 12 bits.
  - BUS_PCLK: driven by a continuous assign of the pclk input, not registered.
- hcount counts 0..H_TOTAL-1. At H_TOTAL-1 it wraps to 0 and vcount increments.
- vcount counts 0..V_TOTAL-1. When hcount=H_TOTAL-1 and vcount=V_TOTAL-1, both wrap to 0.
- Flags are decoded from the counter values they accompany:
  - hblnk = hcount >= H_ACTIVE
  - hsync = H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC
  - vblnk = vcount >= V_ACTIVE
  - vsync = V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC
- Syncs are active-high. The sync/blank output stage registers them unchanged.
- All comparisons are unsigned, 11-bit. Parameter sums must stay below 2048.
- RGB is 12'h000 unless VIDEO_TEST_PATTERN_EN is defined (see Configuration).

## Timing
- Every bus field except PCLK is registered. All registered fields are computed from the next-state counter values, so each beat is self-consistent, with zero skew between count and flags.
- Reset (rst high at a pclk edge) loads:
  - hcount=0, vcount=0
  - hsync, vsync, hblnk, vblnk = 0
  - rgb=12'h000, frame_start=0
- The first edge with rst low gives hcount=1, vcount=0.
- Reset asserted mid-frame: the next edge returns to the reset state, with no partial sync pulse held over.
- frame_start goes high only on a counter wrap into (0,0), never on reset entry. The first pulse appears H_TOTAL*V_TOTAL-1 cycles after reset release.
- Frame period is exactly 663168 pclk cycles. Line period is exactly 1056 cycles.

## Configuration
Macro: VIDEO_TEST_PATTERN_EN.
- Defined: BUS_RGB carries the test pattern, registered coincident with the counters.
  - Inside the active area:
    - Border (hcount 0 or H_ACTIVE-1, or vcount 0 or V_ACTIVE-1): 12'hFFF.
    - Elsewhere, eight 128-pixel bars selected by hcount[9:7]: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
    - Bar index 7 (hcount 896 and up) falls outside the active area at the default timing.
  - Outside the active area: 12'h000.
- Undefined: BUS_RGB is constant 12'h000, and the pattern logic is absent.

## Structure
- video_bus.h owns the `BUS_*` field macros, `BUS_WIDTH` and the MAKE_* unpack macros.
- A shared timing header holds the default 800x600 constants, so that the generator and the benches share one source.
- One sub-module: video_test_pattern. It is combinational and maps next-state hcount/vcount to RGB. It is instantiated only under VIDEO_TEST_PATTERN_EN.

## Test plan
- Hold rst 3 cycles, release -> bus is 0 in all fields except PCLK during reset. First post-reset beat is hcount=1, vcount=0, all flags 0.
- Run one line -> hblnk rises at hcount=800; hsync is high for exactly hcount 840..967; hcount wraps 1055->0 with vcount 0->1.
- Run one full frame -> vblnk rises at vcount=600; vsync is high for vcount 601..604. frame_start pulses once, at (0,0), 663167 cycles after release.
- Assert rst at hcount=900, vcount=602 (inside hsync and vsync) -> the next beat has all flags 0 and counts 0.
- With VIDEO_TEST_PATTERN_EN: (0,0)=FFF, (200,300)=FF0, (700,300)=F00, (799,300)=FFF, (850,300)=000. Without the macro, RGB is 000 throughout.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// rtl/video_timing_gen_pkg.sv - shared 800x600@60 timing defaults and video bus layout
package video_timing_gen_pkg;

   // Default 800x600@60 Hz timing (40 MHz pixel clock); generator and benches share these.
   localparam int unsigned DEF_H_ACTIVE = 800;
   localparam int unsigned DEF_H_FP     = 40;
   localparam int unsigned DEF_H_SYNC   = 128;
   localparam int unsigned DEF_H_BP     = 88;
   localparam int unsigned DEF_V_ACTIVE = 600;
   localparam int unsigned DEF_V_FP     = 1;
   localparam int unsigned DEF_V_SYNC   = 4;
   localparam int unsigned DEF_V_BP     = 23;

   localparam int CNT_W = 11;
   localparam int RGB_W = 12;

   // Video bus field positions, LSB first; PCLK rides on the top bit above the registered beat.
   localparam int BUS_RGB_LSB    = 0;
   localparam int BUS_VBLNK      = 12;
   localparam int BUS_HBLNK      = 13;
   localparam int BUS_VSYNC      = 14;
   localparam int BUS_HSYNC      = 15;
   localparam int BUS_VCOUNT_LSB = 16;
   localparam int BUS_HCOUNT_LSB = 27;
   localparam int BUS_PCLK       = 38;
   localparam int BUS_WIDTH      = 38;

   // Registered part of one bus beat; packed order matches the field positions above.
   typedef struct packed {
      logic [CNT_W-1:0] hcount;
      logic [CNT_W-1:0] vcount;
      logic             hsync;
      logic             vsync;
      logic             hblnk;
      logic             vblnk;
      logic [RGB_W-1:0] rgb;
   } beat_t;

   // Half-open window test used for the sync pulses.
   function automatic logic in_window(input logic [CNT_W-1:0] v,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/video_timing_gen_test_pattern.sv
// rtl/video_timing_gen_test_pattern.sv - colour-bar test pattern, built only with VIDEO_TEST_PATTERN_EN
`ifdef VIDEO_TEST_PATTERN_EN
module video_test_pattern
   import video_timing_gen_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
   input  logic [CNT_W-1:0] hcount,
   input  logic [CNT_W-1:0] vcount,
   output logic [RGB_W-1:0] rgb
);

   localparam logic [CNT_W-1:0] HA = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] VA = CNT_W'(V_ACTIVE);

   // White border around the active area, 128-pixel bars inside, black in blanking.
   always_comb begin
      rgb = '0;
      if ((hcount < HA) && (vcount < VA)) begin
         if ((hcount == '0) || (hcount == HA - 1'b1) || (vcount == '0) || (vcount == VA - 1'b1)) begin
            rgb = 12'hFFF;
         end else begin
            case (hcount[9:7])
               3'd0:    rgb = 12'hFFF;
               3'd1:    rgb = 12'hFF0;
               3'd2:    rgb = 12'h0FF;
               3'd3:    rgb = 12'h0F0;
               3'd4:    rgb = 12'hF0F;
               3'd5:    rgb = 12'hF00;
               3'd6:    rgb = 12'h00F;
               default: rgb = 12'h000;
            endcase
         end
      end
   end

endmodule
`endif

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - 800x600 video timing source; VIDEO_TEST_PATTERN_EN adds the colour-bar pattern
module video_timing_gen
   import video_timing_gen_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP
) (
   input  logic               pclk,
   input  logic               rst,
   output logic [BUS_WIDTH:0] video_bus_out,
   output logic               frame_start
);

   localparam logic [CNT_W-1:0] HA      = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] VA      = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   beat_t            beat_q;
   logic [CNT_W-1:0] h_next;
   logic [CNT_W-1:0] v_next;
   logic [RGB_W-1:0] rgb_next;

   // Next-state counters; every registered field is decoded from these so count and flags never skew.
   always_comb begin
      h_next = beat_q.hcount + 1'b1;
      v_next = beat_q.vcount;
      if (beat_q.hcount == H_LAST) begin
         h_next = '0;
         v_next = (beat_q.vcount == V_LAST) ? '0 : beat_q.vcount + 1'b1;
      end
   end

`ifdef VIDEO_TEST_PATTERN_EN
   video_test_pattern #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE)
   ) u_test_pattern (
      .hcount (h_next),
      .vcount (v_next),
      .rgb    (rgb_next)
   );
`else
   assign rgb_next = '0;
`endif

   // Register one beat per pixel; reset clears everything so no sync pulse survives a mid-frame reset.
   always_ff @(posedge pclk) begin
      if (rst) begin
         beat_q      <= '0;
         frame_start <= 1'b0;
      end else begin
         beat_q.hcount <= h_next;
         beat_q.vcount <= v_next;
         beat_q.hblnk  <= (h_next >= HA);
         beat_q.hsync  <= in_window(h_next, HS_LO, HS_HI);
         beat_q.vblnk  <= (v_next >= VA);
         beat_q.vsync  <= in_window(v_next, VS_LO, VS_HI);
         beat_q.rgb    <= rgb_next;
         frame_start   <= (h_next == '0) && (v_next == '0);
      end
   end

   // PCLK is forwarded combinationally; the rest of the bus is the registered beat.
   assign video_bus_out = {pclk, beat_q};

endmodule
